mux_rr_nd: RTL
==============

# mux_rr_nd

Parametrised, registered N:1 multiplexer with per-input valid/ready handshake and selectable round-robin or fixed-priority arbitration. It generalises the 2-input combinational `mux_2d` to `depth` inputs of `width` bits. The output stage is a single register. It is used where several datapath sources contend for one sink, such as the instruction-fetch and data ports sharing one memory port, or multiple writeback sources.

## Interface
- `width`, 32, bits per input word and output word.
- `depth`, 4, number of inputs. Must be ≥2; non-powers-of-2 are legal.
- `sel_w`, `$clog2(depth)`, width of the select/index fields. Derived; never overridden.

- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `mode` input 1: arbitration mode. 0 = round-robin (MODE_RR); 1 = fixed priority, lowest index wins (MODE_PRIO).
- `din` input `depth*width`: flattened inputs. Input i occupies `din[i*width +: width]`.
- `din_valid` input `depth`: per-input request.
- `din_ready` output `depth`: per-input accept. At most one bit is set in any cycle.
- `mux_out` output `width`: registered selected word.
- `out_sel` output `sel_w`: index of the input that produced `mux_out`.
- `out_valid` output 1: `mux_out` and `out_sel` hold a word.
- `out_ready` input 1: sink accepts the word.

## Operation
- **Load enable:** `load = !out_valid || out_ready`. The output register is free, or it is being drained in this cycle.
- **Grant, round-robin mode:** the first i with `din_valid[i]`, searching from `ptr` upward and wrapping from `depth-1` to 0.
- **Grant, priority mode:** the lowest i with `din_valid[i]`.
- **Ready:** `din_ready[i] = load && grant[i]`. This is purely combinational from `din_valid`, `mode`, `ptr`, `out_valid` and `out_ready`. It never depends on `din`.
- **Input transfer:** occurs when `din_valid[i] && din_ready[i]`. On that edge:
  - `mux_out` takes word i.
  - `out_sel` takes i.
  - `out_valid` goes to 1.
- **Drain with no request:** if `load` is 1 and no input is valid, `out_valid` goes to 0. `mux_out` and `out_sel` keep their previous values, which are don't-care.
- **Stall:** while `out_valid && !out_ready`, `mux_out` and `out_sel` are held stable and all `din_ready` bits are 0.
- **Pointer:** `ptr` is an internal `sel_w`-bit register. It updates only on an input transfer in round-robin mode, to `(i+1) mod depth`. For non-power-of-2 depth, `depth-1` wraps to 0 explicitly, not by overflow. Priority mode leaves `ptr` unchanged.
- **Mode change:** `mode` is sampled each cycle and takes effect on the same cycle's grant. `ptr` is retained across mode changes.
- **Reset values:**
  - `out_valid` = 0.
  - `mux_out` = 0.
  - `out_sel` = 0.
  - `ptr` = 0.
  - `din_ready` = 0 while `reset` is high.
- **Reset mid-operation:** a held, unaccepted word is discarded. No transfer is reported on a reset edge.

## Timing
- **Latency:** 1 cycle from input transfer to `out_valid`.
- **Throughput:** 1 word per cycle when `out_ready` is held at 1.
- **Input handshake:**
  - Sources must hold `din` and `din_valid` until the transfer completes.
  - A source may deassert `din_valid` before being granted; nothing is lost.
- **Output handshake:**
  - A transfer occurs on the edge where `out_valid && out_ready`.
  - The block never deasserts `out_valid` without a transfer, except on reset.
- **Simultaneous drain and load:** a drain and a new load on the same edge is legal. `out_valid` stays at 1 and `mux_out` changes.
- **Combinational paths:** `din_valid` → `din_ready` and `out_ready` → `din_ready`. There is no `din` → output combinational path.

## Structure
- **Shared package / header `mux_pkg`:** holds `MODE_RR` = 1'b0 and `MODE_PRIO` = 1'b1. `mux_2d` users and this block share it.
- **Sub-module `rr_arbiter`:** a combinational unit with parameter `depth`, inputs `req`, `ptr` and `prio_mode`, and outputs one-hot `grant`, `grant_idx` and `any`.
- **Top level:** the top holds `ptr`, the output register, the `load` logic, and the `width`-wide mux built from `grant_idx`.

## Test plan
1. **Reset and idle:** assert `reset` for 2 cycles while `din_valid` = 4'b1111.
   - During reset: `din_ready` = 0.
   - After reset: `out_valid` = 0, `mux_out` = 0, `out_sel` = 0.
2. **Round-robin fairness:** `mode` = 0, `depth` = 4, `din_valid` = 4'b1111 held, `din[i]` = 32'hA0+i, `out_ready` = 1.
   - Required: `out_sel` sequence 0,1,2,3,0,… with `mux_out` = 32'hA0,32'hA1,32'hA2,32'hA3,32'hA0.
   - Required: one word per cycle.
3. **Priority mode:** `mode` = 1, `din_valid` = 4'b1010.
   - Required: input 1 is granted every cycle. Input 3 sees `din_ready` = 0 until `din_valid[1]` drops; input 3 is then granted the next cycle.
4. **Backpressure:** load word 32'hDEAD_BEEF from input 2, then hold `out_ready` = 0 for 5 cycles.
   - During the stall: `mux_out` = 32'hDEAD_BEEF, `out_sel` = 2, all `din_ready` = 0.
   - When `out_ready` returns: the transfer happens and the next grant loads on the same edge.
5. **Non-power-of-2 wrap:** `depth` = 3, all valid, RR mode.
   - Required: `out_sel` 0,1,2,0. Index 3 never appears.
6. **Reset mid-stall:** with `out_valid` = 1 and `out_ready` = 0, pulse `reset`.
   - Next cycle: `out_valid` = 0, `ptr` = 0, so the first grant after reset goes to input 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Arbitration mode encodings, shared between mux_2d users and mux_rr_nd.
package mux_pkg;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter.
// The search starts at ptr (round-robin) or at 0 (priority) and wraps at depth-1.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int depth = 4,
    localparam int sel_w = $clog2(depth)
) (
    input  logic [depth-1:0] req,
    input  logic [sel_w-1:0] ptr,
    input  logic             prio_mode,
    output logic [depth-1:0] grant,
    output logic [sel_w-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int base;
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        base      = prio_mode ? 0 : int'(ptr);
        for (int k = 0; k < depth; k++) begin
            idx = base + k;
            if (idx >= depth) begin
                idx = idx - depth;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = sel_w'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_nd.sv
// Registered N:1 mux with valid/ready handshakes and round-robin or
// fixed-priority arbitration between inputs.
module mux_rr_nd
    import mux_pkg::*;
#(
    parameter  int width = 32,
    parameter  int depth = 4,
    localparam int sel_w = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [depth*width-1:0] din,
    input  logic [depth-1:0]       din_valid,
    output logic [depth-1:0]       din_ready,
    output logic [width-1:0]       mux_out,
    output logic [sel_w-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic             load;
    logic             any;
    logic             prio_mode;
    logic [depth-1:0] grant;
    logic [sel_w-1:0] grant_idx;
    logic [width-1:0] sel_word;

    logic             out_valid_q, out_valid_d;
    logic [width-1:0] mux_out_q, mux_out_d;
    logic [sel_w-1:0] out_sel_q, out_sel_d;
    logic [sel_w-1:0] ptr_q, ptr_d;

    assign prio_mode = (mode == MODE_PRIO);

    rr_arbiter #(.depth(depth)) u_arb (
        .req       (din_valid),
        .ptr       (ptr_q),
        .prio_mode (prio_mode),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Output register is free, or being drained on this edge.
    assign load      = !out_valid_q || out_ready;
    assign din_ready = (load && !reset) ? grant : '0;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < depth; i++) begin
            if (grant_idx == sel_w'(i)) begin
                sel_word = din[i*width +: width];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        mux_out_d   = mux_out_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                mux_out_d = sel_word;
                out_sel_d = grant_idx;
                if (!prio_mode) begin
                    // Explicit wrap so non-power-of-2 depths never reach depth.
                    if (grant_idx == sel_w'(depth - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + sel_w'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            mux_out_q   <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            mux_out_q   <= mux_out_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mux_out   = mux_out_q;
    assign out_sel   = out_sel_q;

endmodule
